// File: rtl/clk_div_bank.sv
// Bank of runtime-programmable clock dividers driven from one oscillator.
// Each channel holds a registered divided clock and a period-start strobe; ratio changes land on period boundaries.
module clk_div_bank #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 5,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                ext_clk,
  input  logic                ext_reset,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync_restart,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic                cfg_ack,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_INIT);

  logic cfg_ok;

  assign cfg_ok = (cfg_div >= DIV_W'(2)) && (int'(cfg_ch) < CHANNELS);

  always_ff @(posedge ext_clk or posedge ext_reset) begin
    if (ext_reset) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_we && cfg_ok;
      cfg_err <= cfg_we && !cfg_ok;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] hi;
    logic             pend;
    logic             run;
    logic             clk_q;
    logic             tick_q;
    logic             wr;
    logic             wrap;

    assign wr      = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));
    assign hi      = div_act - (div_act >> 1);
    assign cnt_inc = cnt + DIV_W'(1);
    assign wrap    = (cnt == div_act - DIV_W'(1));

    always_ff @(posedge ext_clk or posedge ext_reset) begin
      if (ext_reset) begin
        cnt      <= '0;
        div_act  <= DIV_RST;
        div_pend <= DIV_RST;
        pend     <= 1'b0;
        run      <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        if (!ch_en[i]) begin
          run    <= 1'b0;
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          if (!run && pend) begin
            div_act <= div_pend;
            pend    <= 1'b0;
          end
        end else if (!run || sync_restart || wrap) begin
          // Every period start (first start, restart, wrap) is where a pending ratio takes over.
          run    <= 1'b1;
          cnt    <= '0;
          clk_q  <= 1'b1;
          tick_q <= 1'b1;
          if (pend) begin
            div_act <= div_pend;
            pend    <= 1'b0;
          end
        end else begin
          cnt    <= cnt_inc;
          clk_q  <= (cnt_inc < hi);
          tick_q <= 1'b0;
        end
        // A write on the same edge only latches; it overrides any apply above.
        if (wr) begin
          div_pend <= cfg_div;
          pend     <= 1'b1;
        end
      end
    end

    assign pending[i] = pend;
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with three channels: default ratio, rewrites, rejects, restart, enable, async reset.
module tb_clk_div_bank;

  logic       ext_clk = 1'b0;
  logic       ext_reset;
  logic [2:0] ch_en;
  logic       sync_restart;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_ack;
  logic       cfg_err;
  logic [2:0] pending;
  logic [2:0] clk_out;
  logic [2:0] tick;

  int checks = 0;
  int errors = 0;

  clk_div_bank #(.CHANNELS(3), .DIV_W(8), .DIV_INIT(5)) dut (
    .ext_clk(ext_clk), .ext_reset(ext_reset), .ch_en(ch_en), .sync_restart(sync_restart),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .pending(pending), .clk_out(clk_out), .tick(tick)
  );

  always #5 ext_clk = ~ext_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ext_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write(input logic [1:0] ch, input logic [7:0] dv);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = dv;
  endtask

  // Called on a tick sample; counts cycles and high cycles up to the next tick.
  task automatic measure(input int ch, output int period, output int high);
    period = 0;
    high   = 0;
    do begin
      if (clk_out[ch]) high++;
      period++;
      step();
    end while (!tick[ch] && period < 1000);
  endtask

  task automatic wait_tick(input int ch, input string tag);
    int n;
    n = 0;
    step();
    while (!tick[ch] && n < 600) begin
      step();
      n++;
    end
    check(tag, 32'(tick[ch]), 32'd1);
  endtask

  initial begin
    int per, hi, both;
    ext_reset    = 1'b1;
    ch_en        = 3'b001;
    sync_restart = 1'b0;
    cfg_we       = 1'b0;
    cfg_ch       = '0;
    cfg_div      = '0;
    steps(2);
    check("rst_clk", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_ack", 32'(cfg_ack), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);

    // default ratio on ch0
    ext_reset = 1'b0;
    step();
    check("start_tick0", 32'(tick), 32'd1);
    check("start_clk0", 32'(clk_out), 32'd1);
    measure(0, per, hi);
    check("def_period", per, 5);
    check("def_high", hi, 3);
    measure(0, per, hi);
    check("def_period2", per, 5);
    check("def_high2", hi, 3);

    // mid-period rewrite on ch1
    ch_en = 3'b011;
    step();
    check("ch1_start", 32'(tick[1]), 32'd1);
    steps(2);
    check("ch1_cnt2_clk", 32'(clk_out[1]), 32'd1);
    write(2'd1, 8'd8);
    step();
    cfg_we = 1'b0;
    check("rw_ack", 32'(cfg_ack), 32'd1);
    check("rw_err", 32'(cfg_err), 32'd0);
    check("rw_pend", 32'(pending), 32'b010);
    check("rw_clk_cnt3", 32'(clk_out[1]), 32'd0);
    step();
    check("rw_ack_drop", 32'(cfg_ack), 32'd0);
    check("rw_pend_hold", 32'(pending[1]), 32'd1);
    check("rw_no_tick", 32'(tick[1]), 32'd0);
    step();
    check("rw_wrap_tick", 32'(tick[1]), 32'd1);
    check("rw_pend_clr", 32'(pending[1]), 32'd0);
    measure(1, per, hi);
    check("div8_period", per, 8);
    check("div8_high", hi, 4);

    // rejections, back to back
    write(2'd2, 8'd1);
    step();
    check("rej_div_err", 32'(cfg_err), 32'd1);
    check("rej_div_ack", 32'(cfg_ack), 32'd0);
    write(2'd3, 8'd6);
    step();
    cfg_we = 1'b0;
    check("rej_ch_err", 32'(cfg_err), 32'd1);
    check("rej_ch_ack", 32'(cfg_ack), 32'd0);
    step();
    check("rej_err_drop", 32'(cfg_err), 32'd0);
    check("rej_pend", 32'(pending), 32'd0);
    wait_tick(1, "rej_wait");
    measure(1, per, hi);
    check("rej_period", per, 8);
    check("rej_high", hi, 4);

    // max ratio
    write(2'd1, 8'd255);
    step();
    cfg_we = 1'b0;
    check("max_ack", 32'(cfg_ack), 32'd1);
    check("max_pend", 32'(pending[1]), 32'd1);
    wait_tick(1, "max_wait");
    check("max_pend_clr", 32'(pending[1]), 32'd0);
    measure(1, per, hi);
    check("max_period", per, 255);
    check("max_high", hi, 128);

    // idle write on ch2, then phase alignment
    write(2'd2, 8'd8);
    step();
    cfg_we = 1'b0;
    check("idle2_ack", 32'(cfg_ack), 32'd1);
    check("idle2_pend", 32'(pending), 32'b100);
    step();
    check("idle2_pend_clr", 32'(pending), 32'd0);
    ch_en = 3'b111;
    step();
    check("ch2_start", 32'(tick[2]), 32'd1);
    steps(3);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    check("sync_tick", 32'(tick), 32'b111);
    check("sync_clk", 32'(clk_out), 32'b111);
    both = 0;
    for (int k = 1; k < 40; k++) begin
      step();
      if (tick[0] && tick[2]) both++;
    end
    check("sync_between", both, 0);
    step();
    check("sync_40_t0", 32'(tick[0]), 32'd1);
    check("sync_40_t2", 32'(tick[2]), 32'd1);

    // enable control on ch1
    wait_tick(1, "en_wait");
    check("en_clk_hi", 32'(clk_out[1]), 32'd1);
    ch_en = 3'b101;
    step();
    check("dis_clk", 32'(clk_out[1]), 32'd0);
    check("dis_tick", 32'(tick[1]), 32'd0);
    write(2'd1, 8'd6);
    step();
    cfg_we = 1'b0;
    check("en_ack", 32'(cfg_ack), 32'd1);
    check("en_pend", 32'(pending), 32'b010);
    step();
    check("en_pend_clr", 32'(pending), 32'd0);
    ch_en = 3'b111;
    step();
    check("reen_tick", 32'(tick[1]), 32'd1);
    check("reen_clk", 32'(clk_out[1]), 32'd1);
    measure(1, per, hi);
    check("div6_period", per, 6);
    check("div6_high", hi, 3);

    // async reset between edges
    wait_tick(0, "ar_wait");
    write(2'd0, 8'd9);
    step();
    cfg_we = 1'b0;
    check("ar_pre_pend", 32'(pending[0]), 32'd1);
    check("ar_pre_ack", 32'(cfg_ack), 32'd1);
    #2;
    ext_reset = 1'b1;
    #1;
    check("ar_clk", 32'(clk_out), 32'd0);
    check("ar_tick", 32'(tick), 32'd0);
    check("ar_pend", 32'(pending), 32'd0);
    check("ar_ack", 32'(cfg_ack), 32'd0);
    steps(2);
    ext_reset = 1'b0;
    step();
    check("ar_rel_tick", 32'(tick), 32'b111);
    check("ar_rel_clk", 32'(clk_out), 32'b111);
    steps(2);
    check("ar_cnt2_clk", 32'(clk_out), 32'b111);
    step();
    check("ar_cnt3_clk", 32'(clk_out), 32'd0);
    step();
    check("ar_cnt4_tick", 32'(tick), 32'd0);
    step();
    check("ar_wrap_tick", 32'(tick), 32'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
